// File: rtl/regfile_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
// Shared constants for the RegFile write-port arbiter:
//   REG_LENGTH    default write-data width
//   REG_ADDR_LEN  default register-address width
//   STARVE_CNT_W  width of the EX starvation counter (limit range 1..15)
//   grantSrc_t    2-bit encoding of the source of a registered write
// -----------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

   localparam int REG_LENGTH   = 32;
   localparam int REG_ADDR_LEN = 5;
   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'b00,
      GRANT_EX   = 2'b01,
      GRANT_LS   = 2'b10,
      GRANT_COLL = 2'b11
   } grantSrc_t;

endpackage

// File: rtl/regfile_wr_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb_starve_cnt
// Saturating counter of consecutive cycles in which EX wanted the write port
// but was refused. Once it reaches STARVE_LIMIT, the arbiter lets EX win.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset (clears the count)
//   inc       EX valid but not accepted this cycle
//   clr       EX accepted or EX idle this cycle (wins over inc)
//   at_limit  count has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module regfile_wr_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   import regfile_wr_arbiter_pkg::*;

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign at_limit = (count == LIMIT);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single RegFile write port between the EX ALU result and the LS
// load data. LS has fixed priority; EX is forced through after STARVE_LIMIT
// consecutive refused cycles. Same-address requests collide: both are
// accepted, EX data (younger instruction) is written. The chosen write is
// registered, so RegFile sees it one cycle after acceptance. Writes to r0 are
// accepted but produce we=0.
//
// Optional feature: define REGFILE_WR_ARB_STATS_EN to add the write/collision
// statistics counters and their output ports.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   ex_valid/ex_addr/ex_data        EX write request
//   ex_ready                        EX accepted this cycle (combinational)
//   ls_valid/ls_addr/ls_data        LS write request
//   ls_ready                        LS accepted this cycle (combinational)
//   we/wAddr/wData                  registered RegFile write port
//   grant_src                       registered source: 00 none, 01 EX,
//                                   10 LS, 11 collision
//   ex_wr_cnt/ls_wr_cnt/coll_cnt    (stats build only) accepted-request counts
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter int REG_LENGTH   = regfile_wr_arbiter_pkg::REG_LENGTH,
   parameter int REG_ADDR_LEN = regfile_wr_arbiter_pkg::REG_ADDR_LEN,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ex_valid,
   input  logic [REG_ADDR_LEN-1:0] ex_addr,
   input  logic [REG_LENGTH-1:0]   ex_data,
   output logic                    ex_ready,
   input  logic                    ls_valid,
   input  logic [REG_ADDR_LEN-1:0] ls_addr,
   input  logic [REG_LENGTH-1:0]   ls_data,
   output logic                    ls_ready,
   output logic                    we,
   output logic [REG_ADDR_LEN-1:0] wAddr,
   output logic [REG_LENGTH-1:0]   wData,
   output logic [1:0]              grant_src
`ifdef REGFILE_WR_ARB_STATS_EN
   ,
   output logic [15:0]             ex_wr_cnt,
   output logic [15:0]             ls_wr_cnt,
   output logic [15:0]             coll_cnt
`endif
);
   import regfile_wr_arbiter_pkg::*;

   logic                    exGo;
   logic                    lsGo;
   logic                    atLimit;
   grantSrc_t               nextSrc;
   grantSrc_t               grantSrcQ;
   logic [REG_ADDR_LEN-1:0] selAddr;
   logic [REG_LENGTH-1:0]   selData;

   // Starvation guard: count EX refusals, clear on EX acceptance or EX idle.
   regfile_wr_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) starveCnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (ex_valid && !exGo),
      .clr      (!ex_valid || exGo),
      .at_limit (atLimit)
   );

   // Grant decision looks only at valid/addr and the starvation state, never
   // at data. Readies are held low while reset is asserted.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      exGo    = 1'b0;
      lsGo    = 1'b0;
      nextSrc = GRANT_NONE;
      if (rst) begin
         if (ex_valid && ls_valid) begin
            if (ex_addr == ls_addr) begin
               exGo    = 1'b1;
               lsGo    = 1'b1;
               nextSrc = GRANT_COLL;
            end else if (atLimit) begin
               exGo    = 1'b1;
               nextSrc = GRANT_EX;
            end else begin
               lsGo    = 1'b1;
               nextSrc = GRANT_LS;
            end
         end else if (ex_valid) begin
            exGo    = 1'b1;
            nextSrc = GRANT_EX;
         end else if (ls_valid) begin
            lsGo    = 1'b1;
            nextSrc = GRANT_LS;
         end
      end
   end

   assign ex_ready = exGo;
   assign ls_ready = lsGo;

   // EX payload wins whenever EX is granted, which also covers a collision.
   assign selAddr = exGo ? ex_addr : ls_addr;
   assign selData = exGo ? ex_data : ls_data;

   // Registered write port. Address/data hold on idle cycles; only we and
   // grant_src return to their idle values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we        <= 1'b0;
         wAddr     <= '0;
         wData     <= '0;
         grantSrcQ <= GRANT_NONE;
      end else if (exGo || lsGo) begin
         we        <= (selAddr != '0);
         wAddr     <= selAddr;
         wData     <= selData;
         grantSrcQ <= nextSrc;
      end else begin
         we        <= 1'b0;
         grantSrcQ <= GRANT_NONE;
      end
   end

   assign grant_src = grantSrcQ;

`ifdef REGFILE_WR_ARB_STATS_EN
   // Per-source accepted-request counts (r0 included); a collision bumps all
   // three. All wrap modulo 2^16.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_wr_cnt <= '0;
         ls_wr_cnt <= '0;
         coll_cnt  <= '0;
      end else begin
         if (exGo)         ex_wr_cnt <= ex_wr_cnt + 16'd1;
         if (lsGo)         ls_wr_cnt <= ls_wr_cnt + 16'd1;
         if (exGo && lsGo) coll_cnt  <= coll_cnt + 16'd1;
      end
   end
`endif

   // A requester must keep valid asserted until it is accepted.
   exHoldsValid: assert property (@(posedge clk) disable iff (!rst)
      (ex_valid && !ex_ready) |=> ex_valid);
   lsHoldsValid: assert property (@(posedge clk) disable iff (!rst)
      (ls_valid && !ls_ready) |=> ls_valid);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter (STARVE_LIMIT=4). The driver issues one
// request pattern per cycle with hand-computed readies and write results; the
// expected registered write is queued and a monitor compares it on the next
// cycle whenever grant_src reports a write.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [1:0]  src;
   } wr_t;

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_EX   = 2'b01;
   localparam logic [1:0] G_LS   = 2'b10;
   localparam logic [1:0] G_COLL = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic [4:0]  ex_addr = '0;
   logic [31:0] ex_data = '0;
   logic        ex_ready;
   logic        ls_valid = 1'b0;
   logic [4:0]  ls_addr = '0;
   logic [31:0] ls_data = '0;
   logic        ls_ready;
   logic        we;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic [1:0]  grant_src;
`ifdef REGFILE_WR_ARB_STATS_EN
   logic [15:0] ex_wr_cnt;
   logic [15:0] ls_wr_cnt;
   logic [15:0] coll_cnt;
`endif

   int   tests = 0;
   int   fails = 0;
   int   expEx = 0;
   int   expLs = 0;
   int   expColl = 0;
   wr_t  sbQ[$];
   wr_t  mon;

   regfile_wr_arbiter #(
      .REG_LENGTH   (32),
      .REG_ADDR_LEN (5),
      .STARVE_LIMIT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_valid  (ex_valid),
      .ex_addr   (ex_addr),
      .ex_data   (ex_data),
      .ex_ready  (ex_ready),
      .ls_valid  (ls_valid),
      .ls_addr   (ls_addr),
      .ls_data   (ls_data),
      .ls_ready  (ls_ready),
      .we        (we),
      .wAddr     (wAddr),
      .wData     (wData),
      .grant_src (grant_src)
`ifdef REGFILE_WR_ARB_STATS_EN
      ,
      .ex_wr_cnt (ex_wr_cnt),
      .ls_wr_cnt (ls_wr_cnt),
      .coll_cnt  (coll_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_stats(input string tag, input int ex, input int ls, input int coll);
`ifdef REGFILE_WR_ARB_STATS_EN
      check({tag, "_ex_wr_cnt"}, 32'(ex_wr_cnt), 32'(ex));
      check({tag, "_ls_wr_cnt"}, 32'(ls_wr_cnt), 32'(ls));
      check({tag, "_coll_cnt"},  32'(coll_cnt),  32'(coll));
`endif
   endtask

   // One arbitration cycle. Entered at posedge+1; readies are checked at
   // posedge+4 and the expected registered write is queued for the monitor.
   task automatic cycle(input string name,
                        input logic exV, input logic [4:0] exA, input logic [31:0] exD,
                        input logic lsV, input logic [4:0] lsA, input logic [31:0] lsD,
                        input logic expExR, input logic expLsR,
                        input logic expWe, input logic [4:0] expA, input logic [31:0] expD,
                        input logic [1:0] expSrc);
      ex_valid = exV; ex_addr = exA; ex_data = exD;
      ls_valid = lsV; ls_addr = lsA; ls_data = lsD;
      #3;
      check({name, "_ex_ready"}, 32'(ex_ready), 32'(expExR));
      check({name, "_ls_ready"}, 32'(ls_ready), 32'(expLsR));
      if (expExR) expEx++;
      if (expLsR) expLs++;
      if (expExR && expLsR) expColl++;
      if (expExR || expLsR) sbQ.push_back('{we: expWe, addr: expA, data: expD, src: expSrc});
      @(posedge clk);
      #1;
   endtask

   // Monitor: every registered write is compared against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         if (grant_src != G_NONE) begin
            if (sbQ.size() == 0) begin
               check("unexpected_write", 32'(grant_src), 32'(G_NONE));
            end else begin
               mon = sbQ.pop_front();
               check("mon_we",        32'(we),        32'(mon.we));
               check("mon_wAddr",     32'(wAddr),     32'(mon.addr));
               check("mon_wData",     wData,          mon.data);
               check("mon_grant_src", 32'(grant_src), 32'(mon.src));
            end
         end else begin
            check("mon_idle_we", 32'(we), 32'd0);
         end
      end
   end

   initial begin
      // Reset held with both requesters valid.
      ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'h11;
      ls_valid = 1'b1; ls_addr = 5'd2; ls_data = 32'h22;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_ready",  32'(ex_ready),  32'd0);
      check("rst_ls_ready",  32'(ls_ready),  32'd0);
      check("rst_we",        32'(we),        32'd0);
      check("rst_grant_src", 32'(grant_src), 32'(G_NONE));
      check("rst_wAddr",     32'(wAddr),     32'd0);
      check("rst_wData",     wData,          32'd0);
      check_stats("rst", 0, 0, 0);

      // Release: LS granted in the very first cycle, EX keeps waiting.
      rst = 1'b1;
      cycle("release",  1, 5'd1, 32'h11,   1, 5'd2, 32'h22,   0, 1,  1, 5'd2, 32'h22, G_LS);
      cycle("ex_pend",  1, 5'd1, 32'h11,   0, 5'd0, 32'h0,    1, 0,  1, 5'd1, 32'h11, G_EX);

      // EX alone.
      cycle("ex_alone", 1, 5'd3, 32'h1234, 0, 5'd0, 32'h0,    1, 0,  1, 5'd3, 32'h1234, G_EX);

      // Contention: LS re-presents every cycle, EX held; EX forced on the 5th.
      for (int i = 0; i < 4; i++)
         cycle("contend_ls", 1, 5'd6, 32'h5555, 1, 5'd5, 32'hAAAA, 0, 1, 1, 5'd5, 32'hAAAA, G_LS);
      cycle("contend_ex", 1, 5'd6, 32'h5555, 1, 5'd5, 32'hAAAA,  1, 0,  1, 5'd6, 32'h5555, G_EX);
      // Counter cleared by the EX win: LS has priority again.
      cycle("post_starve", 1, 5'd8, 32'h88, 1, 5'd5, 32'hAAAA,   0, 1,  1, 5'd5, 32'hAAAA, G_LS);
      cycle("ex_drain",    1, 5'd8, 32'h88, 0, 5'd0, 32'h0,      1, 0,  1, 5'd8, 32'h88,   G_EX);

      // Collision: same address, EX data wins.
      cycle("collision", 1, 5'd7, 32'h1, 1, 5'd7, 32'h2,         1, 1,  1, 5'd7, 32'h1, G_COLL);

      // r0 write from LS: accepted, write suppressed.
      cycle("ls_r0", 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF,          0, 1,  0, 5'd0, 32'hFFFF, G_LS);

      // Idle: no grant, address/data hold the last values.
      cycle("idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,              0, 0,  0, 5'd0, 32'h0, G_NONE);
      check("idle_hold_wAddr", 32'(wAddr), 32'd0);
      check("idle_hold_wData", wData, 32'hFFFF);
      check_stats("run", expEx, expLs, expColl);

      // Reset between acceptance and the registering edge: no write.
      ex_valid = 1'b1; ex_addr = 5'd9; ex_data = 32'h99;
      #3;
      check("pre_rst_ex_ready", 32'(ex_ready), 32'd1);
      rst = 1'b0;
      #1;
      check("in_rst_ex_ready", 32'(ex_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rst_drop_we",        32'(we),        32'd0);
      check("rst_drop_grant_src", 32'(grant_src), 32'(G_NONE));
      ex_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Reset right after a write was registered: we drops asynchronously.
      ex_valid = 1'b1; ex_addr = 5'd10; ex_data = 32'hA0;
      #3;
      check("reg_ex_ready", 32'(ex_ready), 32'd1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      check("reg_we",    32'(we),    32'd1);
      check("reg_wAddr", 32'(wAddr), 32'd10);
      rst = 1'b0;
      #1;
      check("async_we",        32'(we),        32'd0);
      check("async_grant_src", 32'(grant_src), 32'(G_NONE));
      check("async_wAddr",     32'(wAddr),     32'd0);
      check_stats("midrst", 0, 0, 0);

      // Recovery after reset.
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle("recover", 1, 5'd12, 32'hC, 0, 5'd0, 32'h0,          1, 0,  1, 5'd12, 32'hC, G_EX);
      cycle("final_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 0,  0, 5'd0, 32'h0, G_NONE);

      check("sb_drain", 32'(sbQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single RegFile write port (we/wAddr/wData) between two writeback requesters: the EX ALU result and the load/store unit (LS) load data.
- Arbitrates with fixed priority to LS, plus a starvation guard for EX.
- Registers the chosen write, so RegFile sees one write per cycle, one cycle after acceptance.
- Sits between the EX/LS outputs and the RegFile write port in the CPU top.

Parameters:
- REG_LENGTH, 32, width of write data.
- REG_ADDR_LEN, 5, width of register address.
- STARVE_LIMIT, 4, consecutive EX-blocked cycles before EX is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX has a write pending.
- ex_addr  input  REG_ADDR_LEN  EX destination register.
- ex_data  input  REG_LENGTH  EX result.
- ex_ready  output  1  EX write accepted this cycle (combinational).
- ls_valid  input  1  LS has a load result pending.
- ls_addr  input  REG_ADDR_LEN  LS destination register.
- ls_data  input  REG_LENGTH  LS load data.
- ls_ready  output  1  LS write accepted this cycle (combinational).
- we  output  1  RegFile write enable (registered).
- wAddr  output  REG_ADDR_LEN  RegFile write address (registered).
- wData  output  REG_LENGTH  RegFile write data (registered).
- grant_src  output  2  source of the current registered write: 00 none, 01 EX, 10 LS, 11 collision (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - we=0, wAddr=0, wData=0, grant_src=00; starvation counter=0.
  - ex_ready and ls_ready are forced to 0 while rst=0.
- Handshake: a transfer occurs when valid&&ready.
  - ready depends only on the valid/addr inputs and internal state, never on the requester's data.
  - A requester holds valid/addr/data stable until accepted.
  - Dropping valid before acceptance is illegal; this is checked by assertion.
- Arbitration, per cycle:
  - Only one valid: that source is granted.
  - Both valid, different addr, starve_cnt<STARVE_LIMIT: LS granted, EX waits.
  - Both valid, different addr, starve_cnt==STARVE_LIMIT: EX granted, LS waits.
  - Both valid, same addr: both accepted in the same cycle. EX data is written (EX is the younger instruction), LS data is discarded, and grant_src=11.
  - Neither valid: no grant.
- Output register, at the next clock edge after acceptance:
  - we=1 if the granted addr is nonzero, else we=0.
  - A write to r0 is accepted (ready=1) but suppressed.
  - wAddr/wData take the granted source's values. With no grant: we=0, and wAddr/wData hold their previous values.
- Latency: exactly 1 cycle from acceptance to we. Throughput: 1 write per cycle.
- Starvation counter (4-bit):
  - Increments when ex_valid=1 and ex_ready=0; saturates at STARVE_LIMIT.
  - Clears on EX acceptance or when ex_valid=0.
- Worst-case EX wait is STARVE_LIMIT cycles; worst-case LS wait is 1 cycle.
- Reset asserted mid-operation: the pending registered write is dropped (we=0 immediately, asynchronously), the counter is cleared, and unaccepted requests must be re-presented after reset.
- Reset release: grants may be given in the first cycle with rst=1.

Optional Feature:
- Macro: REGFILE_WR_ARB_STATS_EN.
- Defined: adds output ports ex_wr_cnt[15:0], ls_wr_cnt[15:0] and coll_cnt[15:0].
  - ex_wr_cnt/ls_wr_cnt increment per accepted request of that source (r0 included). A collision increments both, plus coll_cnt.
  - All three wrap modulo 2^16 and reset to 0.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package/defines file: REG_LENGTH, REG_ADDR_LEN, and GRANT_NONE/GRANT_EX/GRANT_LS/GRANT_COLL encodings (2-bit).
- One sub-module, regfile_wr_arb_starve_cnt: the saturating starvation counter with inc/clr inputs and an at_limit output.
- Grant logic and the output register stay in the top.

Test Plan:
- Reset: hold rst=0 with both valid -> ex_ready=ls_ready=0, we=0, grant_src=00. Release -> LS granted in the same cycle.
- EX alone: ex_addr=3, ex_data=0x1234 -> ex_ready=1; next cycle we=1, wAddr=3, wData=0x1234, grant_src=01.
- Contention: ls(addr 5, 0xAAAA) and ex(addr 6, 0x5555) both held valid, LS re-presenting every cycle with STARVE_LIMIT=4 -> LS wins cycles 0-3, EX wins cycle 4, counter then reads 0.
- Collision: ex and ls both addr 7, data 0x1/0x2 -> both ready=1; next cycle wAddr=7, wData=0x1, grant_src=11.
- r0 write: ls_addr=0, ls_data=0xFFFF -> ls_ready=1; next cycle we=0, grant_src=10.
- Mid-operation reset: EX accepted, rst=0 before the next edge -> we goes 0 asynchronously and no write occurs. With REGFILE_WR_ARB_STATS_EN defined, the counters read 0.
